// File: rtl/motion_detector_pipe.sv
// motion_detector_pipe
//   Multi-lane streaming motion detector. Each accepted beat carries LANES
//   pixels. For every lane the block flags motion, from the frame difference
//   and the background difference, and produces an updated background pixel.
//   It also counts motion lanes per frame and raises an alarm when a frame's
//   count reaches alarm_thresh.
//
//   Pipeline: two register stages with a global stall.
//     S1 holds the absolute differences.
//     S2 holds the mask and the background update.
//   An accepted beat reaches the outputs two cycles after it is accepted.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   enable                    0 freezes the whole block
//   in_valid/in_ready         input handshake
//   in_sof/in_eof             frame markers travelling with the beat
//   curr_pixel, prev_pixel,
//   background, variance      LANES packed pixels, lane i = [i*PIX_W +: PIX_W]
//   threshold, mode,
//   alarm_thresh              quasi-static controls
//   out_valid/out_ready       output handshake
//   motion_mask, bg_update,
//   out_eof                   output beat
//   frame_done                one-cycle pulse after an eof beat closes a frame
//   frame_motion_count,
//   frame_alarm               result of the last completed frame, held
module motion_detector_pipe #(
   parameter int PIX_W    = 8,
   parameter int LANES    = 4,
   parameter int BG_SHIFT = 3,
   parameter int CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sof,
   input  logic                   in_eof,
   input  logic [LANES*PIX_W-1:0] curr_pixel,
   input  logic [LANES*PIX_W-1:0] prev_pixel,
   input  logic [LANES*PIX_W-1:0] background,
   input  logic [LANES*PIX_W-1:0] variance,
   input  logic [PIX_W-1:0]       threshold,
   input  logic [1:0]             mode,
   input  logic [CNT_W-1:0]       alarm_thresh,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES-1:0]       motion_mask,
   output logic [LANES*PIX_W-1:0] bg_update,
   output logic                   out_eof,
   output logic                   frame_done,
   output logic [CNT_W-1:0]       frame_motion_count,
   output logic                   frame_alarm
);

   localparam int               VEC_W   = LANES * PIX_W;
   localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // |a - b| without leaving the unsigned pixel range
   function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
      logic [PIX_W-1:0] d;
      if (a >= b) begin
         d = a - b;
      end else begin
         d = b - a;
      end
      return d;
   endfunction

   // bg + ((cur - bg) >>> BG_SHIFT) in signed PIX_W+1 arithmetic, clamped to pixel range
   function automatic logic [PIX_W-1:0] blend_bg(input logic [PIX_W-1:0] cur,
                                                 input logic [PIX_W-1:0] bg);
      logic signed [PIX_W:0] diff;
      logic signed [PIX_W:0] step;
      logic signed [PIX_W:0] sum;
      logic [PIX_W-1:0]      res;
      diff = $signed({1'b0, cur}) - $signed({1'b0, bg});
      step = diff >>> BG_SHIFT;
      sum  = $signed({1'b0, bg}) + step;
      if (sum < $signed({(PIX_W+1){1'b0}})) begin
         res = {PIX_W{1'b0}};
      end else if (sum > $signed({1'b0, PIX_MAX})) begin
         res = PIX_MAX;
      end else begin
         res = sum[PIX_W-1:0];
      end
      return res;
   endfunction

   // Detection mode table: 00 both, 01 frame diff only, 10 background only, 11 either
   function automatic logic motion_sel(input logic fd, input logic bgm, input logic [1:0] md);
      logic m;
      case (md)
         2'b00:   m = fd & bgm;
         2'b01:   m = fd;
         2'b10:   m = bgm;
         2'b11:   m = fd | bgm;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   // Number of motion lanes in a mask
   function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] m);
      logic [CNT_W-1:0] n;
      n = {CNT_W{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         n = n + {{(CNT_W-1){1'b0}}, m[i]};
      end
      return n;
   endfunction

   logic             adv_s;
   logic [VEC_W-1:0] pd_s;
   logic [VEC_W-1:0] bd_s;
   logic             s1_valid_r;
   logic             s1_sof_r;
   logic             s1_eof_r;
   logic [VEC_W-1:0] s1_pd_r;
   logic [VEC_W-1:0] s1_bd_r;
   logic [VEC_W-1:0] s1_bg_r;
   logic [VEC_W-1:0] s1_curr_r;
   logic [VEC_W-1:0] s1_var_r;
   logic [LANES-1:0] mask_s;
   logic [VEC_W-1:0] bg_next_s;
   logic             s2_sof_r;
   logic             xfer_s;
   logic             close_s;
   logic [CNT_W-1:0] pop_s;
   logic [CNT_W:0]   acc_sum_s;
   logic [CNT_W-1:0] acc_sat_s;
   logic [CNT_W-1:0] acc_next_s;
   logic [CNT_W-1:0] acc_r;
   logic             in_frame_r;

   // The whole pipeline moves together; the S2 slot frees up when it is empty or being taken
   assign adv_s    = enable & (~out_valid | out_ready);
   assign in_ready = rst & adv_s;

   // Per-lane absolute frame and background differences for S1
   always_comb begin
      pd_s = {VEC_W{1'b0}};
      bd_s = {VEC_W{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         pd_s[i*PIX_W +: PIX_W] = abs_diff(curr_pixel[i*PIX_W +: PIX_W], prev_pixel[i*PIX_W +: PIX_W]);
         bd_s[i*PIX_W +: PIX_W] = abs_diff(curr_pixel[i*PIX_W +: PIX_W], background[i*PIX_W +: PIX_W]);
      end
   end

   // Stage 1 registers: differences plus the operands S2 still needs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_r <= 1'b0;
         s1_sof_r   <= 1'b0;
         s1_eof_r   <= 1'b0;
         s1_pd_r    <= {VEC_W{1'b0}};
         s1_bd_r    <= {VEC_W{1'b0}};
         s1_bg_r    <= {VEC_W{1'b0}};
         s1_curr_r  <= {VEC_W{1'b0}};
         s1_var_r   <= {VEC_W{1'b0}};
      end else if (adv_s) begin
         s1_valid_r <= in_valid;
         s1_sof_r   <= in_valid & in_sof;
         s1_eof_r   <= in_valid & in_eof;
         s1_pd_r    <= pd_s;
         s1_bd_r    <= bd_s;
         s1_bg_r    <= background;
         s1_curr_r  <= curr_pixel;
         s1_var_r   <= variance;
      end
   end

   // Motion decision and background blend for S2; motion lanes keep their background
   always_comb begin
      mask_s    = {LANES{1'b0}};
      bg_next_s = {VEC_W{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         mask_s[i] = motion_sel(s1_pd_r[i*PIX_W +: PIX_W] > threshold,
                                s1_bd_r[i*PIX_W +: PIX_W] >= s1_var_r[i*PIX_W +: PIX_W],
                                mode);
         if (mask_s[i]) begin
            bg_next_s[i*PIX_W +: PIX_W] = s1_bg_r[i*PIX_W +: PIX_W];
         end else begin
            bg_next_s[i*PIX_W +: PIX_W] = blend_bg(s1_curr_r[i*PIX_W +: PIX_W],
                                                   s1_bg_r[i*PIX_W +: PIX_W]);
         end
      end
   end

   // Stage 2 registers drive the beat outputs directly
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid   <= 1'b0;
         motion_mask <= {LANES{1'b0}};
         bg_update   <= {VEC_W{1'b0}};
         out_eof     <= 1'b0;
         s2_sof_r    <= 1'b0;
      end else if (adv_s) begin
         out_valid   <= s1_valid_r;
         motion_mask <= mask_s;
         bg_update   <= bg_next_s;
         out_eof     <= s1_eof_r;
         s2_sof_r    <= s1_sof_r;
      end
   end

   // Frame accumulator next value for the beat currently on the outputs
   always_comb begin
      xfer_s    = out_valid & out_ready & enable;
      pop_s     = popcount(motion_mask);
      acc_sum_s = {1'b0, acc_r} + {1'b0, pop_s};
      if (acc_sum_s[CNT_W]) begin
         acc_sat_s = CNT_MAX;
      end else begin
         acc_sat_s = acc_sum_s[CNT_W-1:0];
      end
      if (s2_sof_r) begin
         acc_next_s = pop_s;
      end else if (in_frame_r) begin
         acc_next_s = acc_sat_s;
      end else begin
         acc_next_s = acc_r;
      end
      // an eof only closes a frame that was opened (possibly by this same beat)
      close_s = xfer_s & out_eof & (s2_sof_r | in_frame_r);
   end

   // Frame bookkeeping on output transfers; frame_done is a single-cycle pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r              <= {CNT_W{1'b0}};
         in_frame_r         <= 1'b0;
         frame_done         <= 1'b0;
         frame_motion_count <= {CNT_W{1'b0}};
         frame_alarm        <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (xfer_s) begin
            acc_r <= acc_next_s;
            if (close_s) begin
               in_frame_r         <= 1'b0;
               frame_motion_count <= acc_next_s;
               frame_alarm        <= (acc_next_s >= alarm_thresh);
               frame_done         <= 1'b1;
            end else if (s2_sof_r) begin
               in_frame_r <= 1'b1;
            end
         end
      end
   end

endmodule
